// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: FSM states, instruction
// encodings, ALU operation codes and the decoded instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] ALU_LUI  = 2'd3;

  typedef enum logic [3:0] {
    I_ADDU = 4'd0,
    I_SUBU = 4'd1,
    I_ORI  = 4'd2,
    I_LUI  = 4'd3,
    I_LW   = 4'd4,
    I_SW   = 4'd5,
    I_BEQ  = 4'd6,
    I_J    = 4'd7,
    I_ILL  = 4'd8
  } instr_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational classifier: maps the held opcode/funct fields to one
// instruction class, with I_ILL for anything outside the supported set.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] instr
);

  instr_e cls;

  always_comb begin
    cls = I_ILL;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls = I_ADDU;
        else if (funct == FN_SUBU) cls = I_SUBU;
      end
      OP_ORI:  cls = I_ORI;
      OP_LUI:  cls = I_LUI;
      OP_LW:   cls = I_LW;
      OP_SW:   cls = I_SW;
      OP_BEQ:  cls = I_BEQ;
      OP_J:    cls = I_J;
      default: cls = I_ILL;
    endcase
  end

  assign instr = cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencer with
// Moore-style strobes plus ready-qualified handshakes and a retired counter.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        ir_wr,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        pc_jump,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_wr,
  output logic        reg_dst_rd,
  output logic        mem_to_reg,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  instr_e     instr;
  logic [3:0] instr_code;
  logic       retire;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .instr  (instr_code)
  );

  assign instr = instr_e'(instr_code);
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + 32'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    ir_wr       = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    pc_jump     = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_wr      = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        // Reset parks the FSM in FETCH, so the fetch strobes are also
        // qualified by rst_n to stay quiet while reset is held.
        if (imem_ready && rst_n) begin
          ir_wr   = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (instr == I_ILL) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (instr)
          I_ADDU: begin alu_op = ALU_ADD; state_d = WB; end
          I_SUBU: begin alu_op = ALU_SUB; state_d = WB; end
          I_ORI:  begin alu_op = ALU_OR;  alu_src_imm = 1'b1; state_d = WB; end
          I_LUI:  begin alu_op = ALU_LUI; alu_src_imm = 1'b1; state_d = WB; end
          I_LW, I_SW: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            state_d     = MEM;
          end
          I_BEQ: begin
            alu_op    = ALU_SUB;
            pc_branch = zero;
            retire    = 1'b1;
            state_d   = FETCH;
          end
          I_J: begin
            pc_jump = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        if (instr == I_LW) mem_rd = 1'b1;
        else               mem_wr = 1'b1;
        if (dmem_ready) begin
          // Loads still need writeback; stores complete here.
          state_d = (instr == I_LW) ? WB : FETCH;
          retire  = (instr != I_LW);
        end
      end
      WB: begin
        reg_wr     = 1'b1;
        reg_dst_rd = (instr == I_ADDU) || (instr == I_SUBU);
        mem_to_reg = (instr == I_LW);
        retire     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboarded bench for mc_ctrl: per-cycle expected strobe/state vectors are
// queued alongside the stimulus and compared as each cycle is applied.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, imem_ready, dmem_ready;
  logic        ir_wr, pc_inc, pc_branch, pc_jump;
  logic [1:0]  alu_op;
  logic        alu_src_imm, reg_wr, reg_dst_rd, mem_to_reg, mem_rd, mem_wr, illegal;
  logic [31:0] retired;
  logic [2:0]  state;

  mc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .ir_wr       (ir_wr),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .pc_jump     (pc_jump),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .reg_wr      (reg_wr),
    .reg_dst_rd  (reg_dst_rd),
    .mem_to_reg  (mem_to_reg),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .illegal     (illegal),
    .retired     (retired),
    .state       (state)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] B_IRW = 16'h8000, B_PCI = 16'h4000, B_PCB = 16'h2000;
  localparam logic [15:0] B_PCJ = 16'h1000, B_IMM = 16'h0200, B_RW  = 16'h0100;
  localparam logic [15:0] B_RD  = 16'h0080, B_M2R = 16'h0040, B_MRD = 16'h0020;
  localparam logic [15:0] B_MWR = 16'h0010, B_ILL = 16'h0008;
  localparam logic [15:0] S_FETCH = 16'd0, S_DECODE = 16'd1, S_EXEC = 16'd2;
  localparam logic [15:0] S_MEM = 16'd3, S_WB = 16'd4;

  logic [15:0] obs;
  assign obs = {ir_wr, pc_inc, pc_branch, pc_jump, alu_op, alu_src_imm, reg_wr,
                reg_dst_rd, mem_to_reg, mem_rd, mem_wr, illegal, state};

  logic [14:0] stim_q[$];
  logic [15:0] exp_q[$];
  logic [31:0] exp_retired;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] alu(input logic [1:0] a);
    return 16'(a) << 10;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic im,
                      input logic dm, input logic z, input logic [15:0] e);
    stim_q.push_back({op, fn, im, dm, z});
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; don't-care inputs randomised.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int iwait, input int dwait, input bit abort);
    logic rt, legal, mem;
    logic [15:0] ex;
    rt    = (op == 6'h00);
    legal = (rt && (fn == 6'h21 || fn == 6'h23)) ||
            op == 6'h0D || op == 6'h0F || op == 6'h23 ||
            op == 6'h2B || op == 6'h04 || op == 6'h02;
    mem   = (op == 6'h23 || op == 6'h2B);
    for (int i = 0; i < iwait; i++) push(op, fn, 1'b0, rnd(), rnd(), S_FETCH);
    push(op, fn, 1'b1, rnd(), rnd(), B_IRW | B_PCI | S_FETCH);
    if (!legal) begin
      push(op, fn, rnd(), rnd(), rnd(), B_ILL | S_DECODE);
      return;
    end
    push(op, fn, rnd(), rnd(), rnd(), S_DECODE);
    case (op)
      6'h00:        ex = (fn == 6'h21) ? alu(2'd0) : alu(2'd1);
      6'h0D:        ex = alu(2'd2) | B_IMM;
      6'h0F:        ex = alu(2'd3) | B_IMM;
      6'h23, 6'h2B: ex = alu(2'd0) | B_IMM;
      6'h04:        ex = alu(2'd1) | (z ? B_PCB : 16'd0);
      6'h02:        ex = B_PCJ;
      default:      ex = 16'd0;
    endcase
    push(op, fn, rnd(), rnd(), (op == 6'h04) ? z : rnd(), ex | S_EXEC);
    if (mem) begin
      ex = (op == 6'h23) ? B_MRD : B_MWR;
      for (int i = 0; i < dwait; i++) push(op, fn, rnd(), 1'b0, rnd(), ex | S_MEM);
      if (abort) return;
      push(op, fn, rnd(), 1'b1, rnd(), ex | S_MEM);
    end
    if (op != 6'h04 && op != 6'h02 && op != 6'h2B)
      push(op, fn, rnd(), rnd(), rnd(),
           B_RW | (rt ? B_RD : 16'd0) | ((op == 6'h23) ? B_M2R : 16'd0) | S_WB);
    exp_retired++;
  endtask

  task automatic drain(input string tag);
    logic [14:0] s;
    logic [15:0] e;
    int n;
    n = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {opcode, funct, imem_ready, dmem_ready, zero} = s;
      @(negedge clk);
      check_eq($sformatf("%s.c%0d", tag, n), 32'(obs), 32'(e));
      n++;
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int iwait, input int dwait);
    gen(op, fn, z, iwait, dwait, 1'b0);
    drain(tag);
    check_eq({tag, ".retired"}, retired, exp_retired);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
    opcode = 6'h00; funct = 6'h21; exp_retired = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", 32'(obs), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    imem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("addu",    6'h00, 6'h21, 1'b0, 0, 0);
    run("subu",    6'h00, 6'h23, 1'b0, 2, 0);
    run("ori",     6'h0D, 6'h00, 1'b0, 0, 0);
    run("lui",     6'h0F, 6'h3F, 1'b1, 1, 0);
    run("beq_t",   6'h04, 6'h00, 1'b1, 0, 0);
    run("beq_nt",  6'h04, 6'h00, 1'b0, 0, 0);
    run("lw_w3",   6'h23, 6'h00, 1'b0, 0, 3);
    run("sw",      6'h2B, 6'h00, 1'b0, 0, 0);
    run("sw_w1",   6'h2B, 6'h11, 1'b0, 0, 1);
    run("j",       6'h02, 6'h00, 1'b0, 0, 0);
    run("ill_op",  6'h3F, 6'h21, 1'b0, 0, 0);
    run("ill_fn",  6'h00, 6'h20, 1'b0, 0, 0);
    run("lw",      6'h23, 6'h00, 1'b0, 0, 0);

    // Reset asserted mid-cycle while a store sits in MEM.
    gen(6'h2B, 6'h00, 1'b0, 0, 2, 1'b1);
    drain("sw_abort");
    check_eq("sw_abort.pre_mem_wr", 32'(mem_wr), 32'd1);
    imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("sw_abort.outs", 32'(obs), 32'd0);
    check_eq("sw_abort.retired", retired, 32'd0);
    exp_retired = 32'd0;
    imem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run("after_rst", 6'h00, 6'h21, 1'b0, 0, 0);

    force dut.retired = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.retired;
    @(negedge clk);
    check_eq("preset", retired, 32'hFFFF_FFFF);
    exp_retired = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    run("j_wrap", 6'h02, 6'h00, 1'b0, 0, 0);
    check_eq("wrap_zero", retired, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
